mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//   Memory-access (MEM) stage directly downstream of the ID/EX pipeline register.
//   - Consumes memwrite/regwrite/rsdata/rtdata/rd and runs one data-memory transaction per op over a req/ack port.
//   - Stalls the upstream register while a transaction is pending.
//   - Presents registered write-back fields to the WB stage.
// PARAMETERS
//   ADDR_W   10  data-memory word-address width; dmem_addr = rsdata_in[ADDR_W-1:0]
//   TIMEOUT  16  WAIT cycles without ack before abort (used only with DMEM_TIMEOUT_EN; >=1)
// PORTS
//   clk           in   1       single clock, rising edge
//   reset         in   1       asynchronous, active-high
//   memwrite_in   in   1       store request from ID/EX
//   regwrite_in   in   1       load request from ID/EX (when memwrite_in=0)
//   rsdata_in     in   64      address operand
//   rtdata_in     in   64      store data
//   rd_in         in   3       load destination register
//   stall_out     out  1       combinational; hold ID/EX contents while high
//   dmem_req      out  1       transaction request
//   dmem_we       out  1       1=store, 0=load; valid while dmem_req=1
//   dmem_addr     out  ADDR_W  word address
//   dmem_wdata    out  64      store data
//   dmem_ack      in   1       transaction complete; dmem_rdata valid same cycle
//   dmem_rdata    in   64      load data
//   wb_regwrite   out  1       one-cycle write-back strobe
//   wb_rd         out  3       write-back register
//   wb_data       out  64      write-back data
//   dmem_err      out  1       one-cycle abort pulse; tied 0 without DMEM_TIMEOUT_EN
// BEHAVIOUR
//   - Reset (async): state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_regwrite, wb_rd, wb_data, dmem_err all 0.
//     Reset mid-transaction drops dmem_req immediately with no write-back; an ack arriving after reset is ignored.
//   - Op decode, sampled in IDLE:
//       memwrite_in=1                 -> store (regwrite_in ignored)
//       memwrite_in=0, regwrite_in=1  -> load
//       both 0                        -> bubble, stay IDLE
//   - IDLE, op present: at the edge, latch we/addr/wdata/rd, set dmem_req=1, go WAIT. stall_out=0 in IDLE.
//   - WAIT:
//       stall_out = !dmem_ack.
//       On ack: at the edge, dmem_req=0 and go IDLE. For a load, wb_regwrite=1, wb_rd=latched rd, wb_data=dmem_rdata.
//       For a store, wb_regwrite=0.
//   - Timing:
//       req rises 1 cycle after op sampled; dmem_* held stable until ack.
//       Write-back valid the cycle after ack; minimum op-to-op spacing is 2 cycles.
//       Upstream advances on the ack edge; the next op is sampled in the following IDLE cycle.
//   - wb_regwrite and dmem_err are single-cycle pulses; wb_rd and wb_data hold their last value.
//   - An ack seen in IDLE is ignored.
//   - Addresses truncate to ADDR_W bits; no alignment or range check.
// CONFIGURATION
//   DMEM_TIMEOUT_EN defined:
//     - Counter clears on WAIT entry and increments each WAIT cycle without ack.
//     - When it reaches TIMEOUT: drop dmem_req, go IDLE, pulse dmem_err, no write-back; stall_out=0 that cycle.
//     - If ack and timeout occur in the same cycle, ack wins.
//   DMEM_TIMEOUT_EN undefined: no counter; WAIT persists until ack; dmem_err=0.
// TESTING
//   1. Load, rs=0x5, rd=3, ack after 2 WAIT cycles with rdata=0xDEADBEEF
//      -> addr=5, we=0, stall high 2 cycles; wb_regwrite pulse, wb_rd=3, wb_data=0xDEADBEEF.
//   2. Store, rs=0x12, rt=0xA5A5 -> we=1, addr=0x12, wdata=0xA5A5; no wb_regwrite pulse.
//   3. Back-to-back load then store, ack immediate
//      -> two transactions, store req rises 1 cycle after load ack, no op lost or duplicated.
//   4. Reset asserted in WAIT
//      -> req=0 immediately, all outputs 0; ack 1 cycle later produces no write-back.
//   5. Bubble (both 0) and spurious ack in IDLE -> req stays 0, no wb pulse.
//   6. DMEM_TIMEOUT_EN, TIMEOUT=4, no ack -> dmem_err pulses 4 cycles after req; req=0; stall drops; no write-back.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one req/ack data-memory transaction per op, stalls ID/EX while pending.
// Optional DMEM_TIMEOUT_EN: abort a transaction after TIMEOUT unacknowledged WAIT cycles.
module mem_access_stage #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite_in,
    input  logic              regwrite_in,
    input  logic [63:0]       rsdata_in,
    input  logic [63:0]       rtdata_in,
    input  logic [2:0]        rd_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [63:0]       dmem_rdata,
    output logic              wb_regwrite,
    output logic [2:0]        wb_rd,
    output logic [63:0]       wb_data,
    output logic              dmem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t     state;
    state_t     next_state;
    logic       op_c;
    logic       start_c;
    logic       done_c;
    logic       abort_c;
    logic [2:0] lat_rd;

    assign op_c = memwrite_in | regwrite_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (op_c) next_state = S_WAIT;
            S_WAIT: if (dmem_ack || abort_c) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Ack always wins over a coinciding timeout; stall drops on either.
    always_comb begin
        start_c   = 1'b0;
        done_c    = 1'b0;
        stall_out = 1'b0;
        case (state)
            S_IDLE: start_c = op_c;
            S_WAIT: begin
                done_c    = dmem_ack;
                stall_out = !dmem_ack && !abort_c;
            end
            default: ;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             unused_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              tmo_cnt <= '0;
        else if (start_c)                       tmo_cnt <= '0;
        else if (state == S_WAIT && !dmem_ack)  tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    assign abort_c     = (state == S_WAIT) && !dmem_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign unused_bits = ^rsdata_in[63:ADDR_W];
`else
    logic unused_bits;

    assign abort_c     = 1'b0;
    assign unused_bits = ^{rsdata_in[63:ADDR_W], (TIMEOUT != 0)};
`endif

    // Request/address latch and write-back register; wb fields hold between loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            lat_rd      <= '0;
            wb_regwrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            dmem_err    <= 1'b0;
        end else begin
            wb_regwrite <= 1'b0;
            dmem_err    <= abort_c;
            if (start_c) begin
                dmem_req   <= 1'b1;
                dmem_we    <= memwrite_in;
                dmem_addr  <= rsdata_in[ADDR_W-1:0];
                dmem_wdata <= rtdata_in;
                lat_rd     <= rd_in;
            end else if (done_c || abort_c) begin
                dmem_req <= 1'b0;
            end
            if (done_c && !dmem_we) begin
                wb_regwrite <= 1'b1;
                wb_rd       <= lat_rd;
                wb_data     <= dmem_rdata;
            end
        end
    end

endmodule
